// File: rtl/conv_pkg.sv
// Shared definitions for the convolution window sequencer.
//   WIDTH_DEF, CHANNELS_DEF, KERNEL_LEN_DEF : default parameter values
//   state_e                                 : sequencer FSM state encoding
package conv_pkg;

  localparam int unsigned WIDTH_DEF      = 16;
  localparam int unsigned CHANNELS_DEF   = 2;
  localparam int unsigned KERNEL_LEN_DEF = 3;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StBusy,
    StOut
  } state_e;

endpackage

// File: rtl/conv_window_shift.sv
// Sliding sample window with a saturating fill counter.
//   clk_i, reset_i : clock, synchronous active-high reset
//   shift_i        : push sample_i into the newest slot, oldest falls out of index 0
//   clear_i        : reset the fill count (window contents are left in place)
//   sample_i       : incoming multi-channel sample
//   window_o       : window, index 0 oldest, KERNEL_LEN-1 newest
//   full_o         : fill count equals KERNEL_LEN
//   last_slot_o    : fill count is one short of KERNEL_LEN
module conv_window_shift
  import conv_pkg::*;
#(
  parameter int unsigned WIDTH      = WIDTH_DEF,
  parameter int unsigned CHANNELS   = CHANNELS_DEF,
  parameter int unsigned KERNEL_LEN = KERNEL_LEN_DEF
) (
  input  logic                                           clk_i,
  input  logic                                           reset_i,
  input  logic                                           shift_i,
  input  logic                                           clear_i,
  input  logic [CHANNELS-1:0][WIDTH-1:0]                 sample_i,
  output logic [KERNEL_LEN-1:0][CHANNELS-1:0][WIDTH-1:0] window_o,
  output logic                                           full_o,
  output logic                                           last_slot_o
);

  localparam int unsigned CntW = $clog2(KERNEL_LEN + 1);

  logic [KERNEL_LEN-1:0][CHANNELS-1:0][WIDTH-1:0] window_q, window_d;
  logic [CntW-1:0]                                count_q, count_d;

  always_comb begin
    window_d = window_q;
    count_d  = count_q;
    if (shift_i) begin
      for (int unsigned i = 0; i + 1 < KERNEL_LEN; i++) begin
        window_d[i] = window_q[i+1];
      end
      window_d[KERNEL_LEN-1] = sample_i;
      if (count_q != CntW'(KERNEL_LEN)) begin
        count_d = count_q + CntW'(1);
      end
    end
    // Clear wins over the increment: a partial window ending in last is discarded.
    if (clear_i) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      window_q <= '0;
      count_q  <= '0;
    end else begin
      window_q <= window_d;
      count_q  <= count_d;
    end
  end

  assign window_o    = window_q;
  assign full_o      = (count_q == CntW'(KERNEL_LEN));
  assign last_slot_o = (count_q == CntW'(KERNEL_LEN - 1));

endmodule

// File: rtl/conv_window_sequencer.sv
// Collects samples into a sliding window, hands each complete window to an
// external conv node and forwards the node's result downstream.
//   clk_i, reset_i           : clock, synchronous active-high reset
//   data_i, valid_i, last_i  : input sample stream; last_i ends a sequence
//   ready_o                  : sample accepted when valid_i && ready_o
//   node_data_o              : window to the node, index 0 oldest
//   node_start_o             : one-cycle start pulse to the node
//   node_done_i, node_data_i : node result handshake
//   data_o, valid_o, ready_i : result stream to downstream
module conv_window_sequencer
  import conv_pkg::*;
#(
  parameter int unsigned WIDTH      = WIDTH_DEF,
  parameter int unsigned CHANNELS   = CHANNELS_DEF,
  parameter int unsigned KERNEL_LEN = KERNEL_LEN_DEF
) (
  input  logic                                           clk_i,
  input  logic                                           reset_i,
  input  logic [CHANNELS-1:0][WIDTH-1:0]                 data_i,
  input  logic                                           valid_i,
  input  logic                                           last_i,
  output logic                                           ready_o,
  output logic [KERNEL_LEN-1:0][CHANNELS-1:0][WIDTH-1:0] node_data_o,
  output logic                                           node_start_o,
  input  logic                                           node_done_i,
  input  logic [WIDTH-1:0]                               node_data_i,
  output logic [WIDTH-1:0]                               data_o,
  output logic                                           valid_o,
  input  logic                                           ready_i
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             last_q, last_d;

  logic accept;
  logic full;
  logic last_slot;
  logic completes;
  logic clear;

  assign accept    = valid_i && ready_o;
  // Acceptance leaves the window full if it was full already or one short.
  assign completes = full || last_slot;
  assign clear     = (accept && last_i && !completes) ||
                     (state_q == StOut && ready_i && last_q);

  conv_window_shift #(
    .WIDTH      (WIDTH),
    .CHANNELS   (CHANNELS),
    .KERNEL_LEN (KERNEL_LEN)
  ) u_shift (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .shift_i     (accept),
    .clear_i     (clear),
    .sample_i    (data_i),
    .window_o    (node_data_o),
    .full_o      (full),
    .last_slot_o (last_slot)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (accept && completes) begin
          state_d = StStart;
          last_d  = last_i;
        end
      end
      StStart: state_d = StBusy;
      StBusy: begin
        if (node_done_i) begin
          data_d  = node_data_i;
          state_d = StOut;
        end
      end
      StOut: begin
        if (ready_i) begin
          state_d = StIdle;
          last_d  = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  // Gate with reset so the upstream never sees a ready while reset is held.
  assign ready_o      = (state_q == StIdle) && !reset_i;
  assign node_start_o = (state_q == StStart);
  assign valid_o      = (state_q == StOut);
  assign data_o       = data_q;

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Randomised self-checking bench for conv_window_sequencer with a queue-based
// reference of the accepted-sample history and a behavioural conv node.
module tb_conv_window_sequencer;

  localparam int W = 16;
  localparam int C = 2;
  localparam int K = 3;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [C-1:0][W-1:0]       data_in;
  logic                      valid_in;
  logic                      last_in;
  logic                      ready_out;
  logic [K-1:0][C-1:0][W-1:0] node_win;
  logic                      node_start;
  logic                      node_done;
  logic [W-1:0]              node_res;
  logic [W-1:0]              data_out;
  logic                      valid_out;
  logic                      ready_in;

  int n_cmp = 0;
  int n_bad = 0;

  logic [C*W-1:0] hist[$];

  always #5 clk = ~clk;

  conv_window_sequencer #(
    .WIDTH      (W),
    .CHANNELS   (C),
    .KERNEL_LEN (K)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .data_i       (data_in),
    .valid_i      (valid_in),
    .last_i       (last_in),
    .ready_o      (ready_out),
    .node_data_o  (node_win),
    .node_start_o (node_start),
    .node_done_i  (node_done),
    .node_data_i  (node_res),
    .data_o       (data_out),
    .valid_o      (valid_out),
    .ready_i      (ready_in)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected window: the K most recent accepted samples, oldest at index 0.
  function automatic logic [K*C*W-1:0] exp_window();
    logic [K*C*W-1:0] w;
    w = '0;
    for (int i = 0; i < hist.size() && i < K; i++) w[i*C*W +: C*W] = hist[i];
    return w;
  endfunction

  task automatic do_reset();
    reset    = 1'b1;
    valid_in = 1'b0;
    last_in  = 1'b0;
    node_done = 1'b0;
    ready_in = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_ready", 128'(ready_out), 128'(0));
    check_eq("rst_start", 128'(node_start), 128'(0));
    check_eq("rst_valid", 128'(valid_out), 128'(0));
    check_eq("rst_data", 128'(data_out), 128'(0));
    check_eq("rst_window", 128'(node_win), 128'(0));
    reset = 1'b0;
    hist.delete();
    @(negedge clk);
    check_eq("post_rst_ready", 128'(ready_out), 128'(1));
  endtask

  // Called at the negedge right after a window-completing acceptance.
  task automatic run_conv(input logic [W-1:0] res, input int delay, input int stall,
                          input logic last);
    logic [K*C*W-1:0] win;
    win = exp_window();
    check_eq("start_pulse", 128'(node_start), 128'(1));
    check_eq("window", 128'(node_win), 128'(win));
    check_eq("ready_in_start", 128'(ready_out), 128'(0));
    @(negedge clk);
    check_eq("start_once", 128'(node_start), 128'(0));
    for (int j = 1; j < delay; j++) begin
      check_eq("busy_valid", 128'(valid_out), 128'(0));
      @(negedge clk);
    end
    check_eq("busy_window", 128'(node_win), 128'(win));
    node_done = 1'b1;
    node_res  = res;
    @(negedge clk);
    node_done = 1'b0;
    node_res  = W'($urandom);
    check_eq("out_valid", 128'(valid_out), 128'(1));
    check_eq("out_data", 128'(data_out), 128'(res));
    for (int j = 0; j < stall; j++) begin
      @(negedge clk);
      check_eq("hold_valid", 128'(valid_out), 128'(1));
      check_eq("hold_data", 128'(data_out), 128'(res));
    end
    ready_in = 1'b1;
    @(negedge clk);
    ready_in = 1'b0;
    check_eq("idle_valid", 128'(valid_out), 128'(0));
    check_eq("idle_ready", 128'(ready_out), 128'(1));
    if (last) hist.delete();
  endtask

  task automatic send(input logic [C*W-1:0] s, input logic last, input int delay,
                      input int stall, input logic [W-1:0] res);
    check_eq("ready_idle", 128'(ready_out), 128'(1));
    valid_in = 1'b1;
    data_in  = s;
    last_in  = last;
    @(negedge clk);
    valid_in = 1'b0;
    last_in  = 1'b0;
    hist.push_back(s);
    if (hist.size() > K) void'(hist.pop_front());
    if (hist.size() == K) begin
      run_conv(res, delay, stall, last);
    end else begin
      check_eq("no_start", 128'(node_start), 128'(0));
      check_eq("ready_partial", 128'(ready_out), 128'(1));
      if (last) hist.delete();
    end
  endtask

  task automatic idle_done();
    node_done = 1'b1;
    node_res  = W'($urandom);
    @(negedge clk);
    node_done = 1'b0;
    check_eq("idle_done_valid", 128'(valid_out), 128'(0));
    check_eq("idle_done_ready", 128'(ready_out), 128'(1));
  endtask

  initial begin
    data_in  = '0;
    node_res = '0;
    do_reset();

    // Directed: first window, stalled downstream.
    send(32'h0002_0004, 1'b0, 8, 5, 16'h0000);
    send(32'h0003_0005, 1'b0, 8, 5, 16'h0000);
    send(32'h0007_0009, 1'b0, 8, 5, 16'h0064);
    check_eq("win_first", 128'(node_win), 128'h0007_0009_0003_0005_0002_0004);
    send(32'h0006_0008, 1'b0, 3, 0, 16'h1234);
    check_eq("win_slide", 128'(node_win), 128'h0006_0008_0007_0009_0003_0005);

    // last on a completing sample runs it, then restarts the fill.
    send(32'h000a_000b, 1'b1, 2, 1, 16'hbeef);
    send(32'h0011_0011, 1'b0, 1, 0, 16'h0000);
    send(32'h0022_0022, 1'b1, 1, 0, 16'h0000);
    send(32'h0101_0101, 1'b0, 1, 0, 16'h0000);
    send(32'h0202_0202, 1'b0, 1, 0, 16'h0000);
    send(32'h0303_0303, 1'b0, 4, 2, 16'h5a5a);
    check_eq("win_fresh", 128'(node_win), 128'h0303_0303_0202_0202_0101_0101);

    // Reset while the node is busy, then a late done.
    valid_in = 1'b1;
    data_in  = 32'hcafe_f00d;
    @(negedge clk);
    valid_in = 1'b0;
    check_eq("pre_rst_start", 128'(node_start), 128'(1));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("busy_rst_ready", 128'(ready_out), 128'(0));
    reset = 1'b0;
    hist.delete();
    node_done = 1'b1;
    node_res  = 16'hdead;
    @(negedge clk);
    node_done = 1'b0;
    check_eq("late_done_valid", 128'(valid_out), 128'(0));
    check_eq("late_done_data", 128'(data_out), 128'(0));
    check_eq("late_done_window", 128'(node_win), 128'(0));
    check_eq("late_done_ready", 128'(ready_out), 128'(1));
    @(negedge clk);
    check_eq("late_done_valid2", 128'(valid_out), 128'(0));

    idle_done();

    // Random traffic.
    for (int n = 0; n < 80; n++) begin
      logic [C*W-1:0] s;
      logic           last;
      s    = $urandom;
      last = ($urandom_range(4, 0) == 0);
      send(s, last, $urandom_range(10, 1), $urandom_range(4, 0), W'($urandom));
      if ($urandom_range(3, 0) == 0) idle_done();
      if ($urandom_range(20, 0) == 0) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/conv_window_sequencer.md
CONV_WINDOW_SEQUENCER -- requirements
Module: conv_window_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the sample and result width in bits.
REQ-002 SHALL have parameter CHANNELS, default 2, giving the number of channels per sample.
REQ-003 SHALL have parameter KERNEL_LEN, default 3, giving the window depth in samples.
REQ-004 SHALL have port clk_i  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port reset_i  input  1  synchronous, active-high reset.
REQ-006 SHALL have port data_i  input  [CHANNELS-1:0][WIDTH-1:0]  incoming sample.
REQ-007 SHALL have port valid_i  input  1  data_i is valid.
REQ-008 SHALL have port last_i  input  1  this sample ends the current sequence; qualified by valid_i.
REQ-009 SHALL have port ready_o  output  1  block accepts a sample this cycle.
REQ-010 SHALL have port node_data_o  output  [KERNEL_LEN-1:0][CHANNELS-1:0][WIDTH-1:0]  window to the conv node; index 0 oldest, KERNEL_LEN-1 newest.
REQ-011 SHALL have port node_start_o  output  1  one-cycle start pulse to the conv node.
REQ-012 SHALL have port node_done_i  input  1  conv node result valid.
REQ-013 SHALL have port node_data_i  input  WIDTH  conv node result.
REQ-014 SHALL have port data_o  output  WIDTH  result forwarded downstream.
REQ-015 SHALL have port valid_o  output  1  data_o is valid.
REQ-016 SHALL have port ready_i  input  1  downstream accepts data_o.

Function
REQ-017 SHALL implement FSM states IDLE, START, BUSY and OUT.
REQ-018 A sample SHALL be accepted only when valid_i and ready_o are both high; ready_o SHALL be high only in IDLE.
REQ-019 On acceptance the window SHALL shift toward index 0, data_i SHALL enter index KERNEL_LEN-1, and the fill count SHALL saturate at KERNEL_LEN.
REQ-020 IDLE->START SHALL occur on any acceptance after which the fill count equals KERNEL_LEN.
REQ-021 In START, node_start_o SHALL be 1 for exactly one cycle, followed by an unconditional transition to BUSY.
REQ-022 node_data_o SHALL hold stable from START until the transition out of BUSY.
REQ-023 In BUSY, node_done_i=1 SHALL capture node_data_i into the data_o register, followed by a transition to OUT.
REQ-024 node_done_i outside BUSY SHALL be ignored.
REQ-025 In OUT, valid_o SHALL be 1 and data_o SHALL be held until ready_i=1, followed by a transition to IDLE.
REQ-026 Latency: node_start_o SHALL rise the cycle after the window-completing acceptance, and valid_o SHALL rise the cycle after node_done_i is sampled.
REQ-027 last_i accepted on a window-completing sample SHALL run that convolution and then clear the fill count to 0 on the OUT handshake.
REQ-028 last_i accepted while the fill count is below KERNEL_LEN SHALL clear the fill count to 0 with no start, discarding the partial window.
REQ-029 Once full, each subsequent accepted sample SHALL trigger exactly one convolution (sliding window, stride 1).

Reset
REQ-030 While reset_i=1 at a rising edge: state SHALL become IDLE, fill count 0, window registers 0, the last flag 0, and node_start_o, valid_o and data_o 0.
REQ-031 ready_o SHALL be 0 during reset and 1 on the first cycle after reset deasserts.
REQ-032 Reset mid-operation (START/BUSY/OUT) SHALL abandon the window, and a late node_done_i SHALL be ignored per REQ-024.

Structure
REQ-033 WIDTH, CHANNELS and KERNEL_LEN defaults and the state enum SHALL live in the shared package conv_pkg.
REQ-034 The window shift register and fill counter SHALL be a sub-module conv_window_shift (inputs: shift enable, clear, sample; outputs: window, full).
REQ-035 The FSM and output register SHALL reside in conv_window_sequencer.

Verification
REQ-036 After reset, accept {ch1,ch0}={0x0002,0x0004}, {0x0003,0x0005}, {0x0007,0x0009} -> node_data_o[0..2]=0x00020004, 0x00030005, 0x00070009; one node_start_o pulse the cycle after the third acceptance; ready_o=0 from START.
REQ-037 Node model returns node_data_i=0x0064 with done 8 cycles after start, ready_i=0 for 5 cycles -> valid_o=1 next cycle, data_o=0x0064 held 5 cycles, then IDLE.
REQ-038 Then accept {0x0006,0x0008} -> node_data_o=0x00030005, 0x00070009, 0x00060008; exactly one start pulse.
REQ-039 Accept 2 samples with last_i=1 on the 2nd -> no start; the next 3 samples form a fresh window, not mixed with the prior data.
REQ-040 Assert reset_i during BUSY, then pulse node_done_i -> all outputs 0, valid_o never asserts, ready_o=1.
REQ-041 node_done_i pulsed in IDLE with valid_i=0 -> no state change, valid_o stays 0.
